// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/flush controller: FSM encoding, shadow-record
// field layout and pipeline slot indices.
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    // Shadow record layout, LSB first: valid, reg_write, is_load, then dst.
    localparam int REC_VALID = 0;
    localparam int REC_WRITE = 1;
    localparam int REC_LOAD  = 2;
    localparam int REC_DST   = 3;

    localparam int ZERO_REG    = 0;
    localparam int FLUSH_CNT_W = 3;

    localparam int PIPE_DEPTH = 3;
    localparam int SLOT_EX    = 0;
    localparam int SLOT_MEM   = 1;
    localparam int SLOT_WB    = 2;

    function automatic int rec_width(input int addr_w);
        return REC_DST + addr_w;
    endfunction

endpackage

// File: rtl/hazard_record_pipe.sv
// Shadow EX/MEM/WB destination records that track in-flight instructions
// alongside the real pipeline.
module hazard_record_pipe
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    localparam int RW = rec_width(REG_ADDR_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          bubble,
    input  logic          clear_front,
    input  logic [RW-1:0] id_rec,
    output logic [RW-1:0] ex_rec,
    output logic [RW-1:0] mem_rec,
    output logic [RW-1:0] wb_rec
);

    logic [RW-1:0] slot_reg  [PIPE_DEPTH];
    logic [RW-1:0] slot_next [PIPE_DEPTH];

    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            slot_next[i] = slot_reg[i];
        end
        if (advance) begin
            slot_next[SLOT_EX]  = bubble ? '0 : id_rec;
            slot_next[SLOT_MEM] = slot_reg[SLOT_EX];
            slot_next[SLOT_WB]  = slot_reg[SLOT_MEM];
        end
        // A taken branch kills the wrong-path work that would occupy EX and MEM.
        if (clear_front) begin
            slot_next[SLOT_EX]  = '0;
            slot_next[SLOT_MEM] = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (!rst) begin
                slot_reg[i] <= '0;
            end else begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end

    assign ex_rec  = slot_reg[SLOT_EX];
    assign mem_rec = slot_reg[SLOT_MEM];
    assign wb_rec  = slot_reg[SLOT_WB];

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard detection, branch/jump flush sequencing and saturating
// stall/flush event counters for the five-stage core.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_is_jump,
    input  logic                  branch_taken,
    output logic                  stall_pipeline,
    output logic                  pc_write_enable,
    output logic                  if_flush,
    output logic                  ex_flush,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int RW = rec_width(REG_ADDR_W);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE    = FLUSH_CNT_W'(1);
    localparam logic [REG_ADDR_W-1:0]  ZERO_ADDR    = REG_ADDR_W'(ZERO_REG);

    logic [RW-1:0]         id_rec;
    logic [RW-1:0]         ex_rec;
    logic [RW-1:0]         mem_rec;
    logic [RW-1:0]         wb_rec;
    logic                  ex_valid;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_dst;
    logic                  rs_hit;
    logic                  rt_hit;
    logic                  load_use;
    logic                  branch_flush;
    logic                  jump_apply;

    hz_state_e               state_reg;
    hz_state_e               state_next;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_reg;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_next;
    logic [1:0]              cnt_event;

    assign id_rec[REC_VALID]             = id_valid;
    assign id_rec[REC_WRITE]             = id_reg_write;
    assign id_rec[REC_LOAD]              = id_is_load;
    assign id_rec[REC_DST +: REG_ADDR_W] = id_dst;

    hazard_record_pipe #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_records (
        .clk         (clk),
        .rst         (rst),
        .advance     (1'b1),
        .bubble      (stall_pipeline),
        .clear_front (branch_taken),
        .id_rec      (id_rec),
        .ex_rec      (ex_rec),
        .mem_rec     (mem_rec),
        .wb_rec      (wb_rec)
    );

    assign ex_valid   = ex_rec[REC_VALID];
    assign ex_is_load = ex_rec[REC_LOAD];
    assign ex_dst     = ex_rec[REC_DST +: REG_ADDR_W];

    // MEM/WB forwarding covers ALU results, so only a load sitting in EX can stall.
    assign rs_hit   = id_uses_rs && (id_rs == ex_dst);
    assign rt_hit   = id_uses_rt && (id_rt == ex_dst);
    assign load_use = id_valid && ex_valid && ex_is_load &&
                      (ex_dst != ZERO_ADDR) && (rs_hit || rt_hit);

    // Older records and the write flag stay visible for debug but drive nothing here.
    logic unused_rec_bits;
    assign unused_rec_bits = ^{ex_rec[REC_WRITE], mem_rec, wb_rec};

    always_comb begin
        state_next      = state_reg;
        flush_cnt_next  = flush_cnt_reg;
        branch_flush    = 1'b0;
        jump_apply      = 1'b0;
        stall_pipeline  = 1'b0;
        pc_write_enable = 1'b1;
        if_flush        = 1'b0;
        ex_flush        = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (branch_taken && (FLUSH_CYCLES > 1)) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_RELOAD;
                end
            end
            ST_FLUSH: begin
                if (branch_taken && (FLUSH_CYCLES > 1)) begin
                    flush_cnt_next = FLUSH_RELOAD;
                end else begin
                    flush_cnt_next = flush_cnt_reg - FLUSH_ONE;
                    if (flush_cnt_reg <= FLUSH_ONE) begin
                        state_next     = ST_RUN;
                        flush_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next     = ST_RUN;
                flush_cnt_next = '0;
            end
        endcase

        // Priority: branch flush, then load-use stall, then jump.
        branch_flush    = branch_taken || (state_reg == ST_FLUSH);
        stall_pipeline  = load_use && !branch_flush;
        jump_apply      = id_is_jump && !branch_flush && !load_use;
        pc_write_enable = !stall_pipeline;
        if_flush        = branch_flush || jump_apply;
        ex_flush        = branch_flush;

        if (!rst) begin
            stall_pipeline  = 1'b0;
            pc_write_enable = 1'b0;
            if_flush        = 1'b1;
            ex_flush        = 1'b1;
            jump_apply      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Flush events count the triggering branch or jump, never the individual flush cycles.
    assign cnt_event[0] = stall_pipeline;
    assign cnt_event[1] = branch_taken || jump_apply;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    count_reg <= '0;
                end else if (cnt_event[gi] && (count_reg != {CNT_W{1'b1}})) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_count = g_cnt[0].count_reg;
    assign flush_count = g_cnt[1].count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against an instruction-level
// reference model.
module tb_hazard_ctrl;

    localparam int AW   = 5;
    localparam int FC   = 3;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_reg_write;
    logic          id_is_load;
    logic [AW-1:0] id_dst;
    logic          id_is_jump;
    logic          branch_taken;
    logic          stall_pipeline;
    logic          pc_write_enable;
    logic          if_flush;
    logic          ex_flush;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W   (AW),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .id_dst          (id_dst),
        .id_is_jump      (id_is_jump),
        .branch_taken    (branch_taken),
        .stall_pipeline  (stall_pipeline),
        .pc_write_enable (pc_write_enable),
        .if_flush        (if_flush),
        .ex_flush        (ex_flush),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit v;
        bit w;
        bit ld;
        int dst;
    } inst_t;

    inst_t inflight [3];
    int    m_stalls;
    int    m_flushes;
    int    cyc;
    int    last_br;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic inst_t empty_inst();
        inst_t e;
        e.v   = 1'b0;
        e.w   = 1'b0;
        e.ld  = 1'b0;
        e.dst = 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) inflight[i] = empty_inst();
        m_stalls  = 0;
        m_flushes = 0;
        last_br   = -1000;
    endtask

    task automatic set_idle();
        rst          = 1'b1;
        id_valid     = 1'b0;
        id_rs        = '0;
        id_rt        = '0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
        id_dst       = '0;
        id_is_jump   = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Explicit combinational expectations for a directed cycle (inputs already applied).
    task automatic peek(input string tag, input logic e_st, input logic e_pc,
                        input logic e_if, input logic e_ex);
        #1;
        check({tag, ".stall"}, 32'(stall_pipeline), 32'(e_st));
        check({tag, ".pcwe"},  32'(pc_write_enable), 32'(e_pc));
        check({tag, ".iff"},   32'(if_flush), 32'(e_if));
        check({tag, ".exf"},   32'(ex_flush), 32'(e_ex));
    endtask

    // One clock: compare every output to the model, then advance the model past the edge.
    task automatic step(input string tag);
        bit    hz;
        bit    br;
        bit    stl;
        bit    jmp;
        inst_t incoming;
        #1;
        hz  = id_valid && inflight[0].v && inflight[0].ld && (inflight[0].dst != 0) &&
              ((id_uses_rs && (int'(id_rs) == inflight[0].dst)) ||
               (id_uses_rt && (int'(id_rt) == inflight[0].dst)));
        br  = branch_taken || (((cyc - last_br) >= 1) && ((cyc - last_br) < FC));
        stl = hz && !br;
        jmp = id_is_jump && !br && !hz;

        if (!rst) begin
            check({tag, ".stall"}, 32'(stall_pipeline), 32'd0);
            check({tag, ".pcwe"},  32'(pc_write_enable), 32'd0);
            check({tag, ".iff"},   32'(if_flush), 32'd1);
            check({tag, ".exf"},   32'(ex_flush), 32'd1);
        end else begin
            check({tag, ".stall"}, 32'(stall_pipeline), 32'(stl));
            check({tag, ".pcwe"},  32'(pc_write_enable), 32'(!stl));
            check({tag, ".iff"},   32'(if_flush), 32'(br || jmp));
            check({tag, ".exf"},   32'(ex_flush), 32'(br));
        end
        check({tag, ".scnt"}, 32'(stall_count), 32'(m_stalls));
        check({tag, ".fcnt"}, 32'(flush_count), 32'(m_flushes));

        if (!rst) begin
            model_reset();
        end else begin
            if (stl && (m_stalls < CMAX)) m_stalls++;
            if ((branch_taken || jmp) && (m_flushes < CMAX)) m_flushes++;
            incoming = empty_inst();
            if (!stl && !branch_taken) begin
                incoming.v   = id_valid;
                incoming.w   = id_reg_write;
                incoming.ld  = id_is_load;
                incoming.dst = int'(id_dst);
            end
            inflight[2] = inflight[1];
            inflight[1] = branch_taken ? empty_inst() : inflight[0];
            inflight[0] = incoming;
            if (branch_taken) last_br = cyc;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        cyc = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state
        step("rst0");
        step("rst1");
        check("rst.scnt0", 32'(stall_count), 32'd0);
        rst = 1'b1;

        // Load r3 in EX, ID reads r3: one stall cycle, then a bubble.
        set_idle();
        id_valid = 1'b1; id_reg_write = 1'b1; id_is_load = 1'b1; id_dst = 5'd3;
        step("lu0");
        id_is_load = 1'b0; id_dst = 5'd7; id_uses_rs = 1'b1; id_rs = 5'd3;
        peek("lu.hit", 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu1");
        peek("lu.after", 1'b0, 1'b1, 1'b0, 1'b0);
        check("lu.scnt", 32'(stall_count), 32'd1);
        step("lu2");

        // Register 0 and ALU results never stall.
        set_idle();
        id_valid = 1'b1; id_reg_write = 1'b1; id_is_load = 1'b1; id_dst = 5'd0;
        step("r0a");
        id_is_load = 1'b0; id_dst = 5'd8; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        id_rs = 5'd0; id_rt = 5'd0;
        peek("r0", 1'b0, 1'b1, 1'b0, 1'b0);
        step("r0b");
        set_idle();
        id_valid = 1'b1; id_reg_write = 1'b1; id_dst = 5'd5;
        step("alua");
        id_dst = 5'd9; id_uses_rs = 1'b1; id_rs = 5'd5;
        peek("alu", 1'b0, 1'b1, 1'b0, 1'b0);
        step("alub");

        // Taken branch: flush for FC cycles, counted once.
        set_idle();
        branch_taken = 1'b1;
        peek("br.t0", 1'b0, 1'b1, 1'b1, 1'b1);
        step("br0");
        branch_taken = 1'b0;
        peek("br.t1", 1'b0, 1'b1, 1'b1, 1'b1);
        step("br1");
        peek("br.t2", 1'b0, 1'b1, 1'b1, 1'b1);
        step("br2");
        peek("br.t3", 1'b0, 1'b1, 1'b0, 1'b0);
        check("br.fcnt", 32'(flush_count), 32'd1);
        step("br3");

        // Branch and load-use together: flush wins, no stall counted.
        set_idle();
        id_valid = 1'b1; id_reg_write = 1'b1; id_is_load = 1'b1; id_dst = 5'd6;
        step("bl0");
        id_is_load = 1'b0; id_dst = 5'd10; id_uses_rt = 1'b1; id_rt = 5'd6;
        branch_taken = 1'b1;
        peek("brlu", 1'b0, 1'b1, 1'b1, 1'b1);
        step("bl1");
        set_idle();
        step("bl2");
        step("bl3");
        check("brlu.scnt", 32'(stall_count), 32'd1);
        check("brlu.fcnt", 32'(flush_count), 32'd2);

        // Jump in RUN with no hazard.
        set_idle();
        id_valid = 1'b1; id_is_jump = 1'b1;
        peek("jmp", 1'b0, 1'b1, 1'b1, 1'b0);
        step("jmp0");
        id_is_jump = 1'b0;
        peek("jmp.next", 1'b0, 1'b1, 1'b0, 1'b0);
        step("jmp1");
        check("jmp.fcnt", 32'(flush_count), 32'd3);

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) != 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_rs        = AW'($urandom_range(0, 3));
            id_rt        = AW'($urandom_range(0, 3));
            id_uses_rs   = $urandom_range(0, 1) != 0;
            id_uses_rt   = $urandom_range(0, 1) != 0;
            id_is_load   = ($urandom_range(0, 4) < 2);
            id_reg_write = id_is_load || ($urandom_range(0, 1) != 0);
            id_dst       = AW'($urandom_range(0, 3));
            id_is_jump   = ($urandom_range(0, 9) == 0);
            branch_taken = ($urandom_range(0, 11) == 0);
            step("rand");
        end
        set_idle();
        rst = 1'b0;
        step("rrst");

        // Saturate the stall counter: a held load-then-use stalls every other cycle.
        set_idle();
        id_valid = 1'b1; id_reg_write = 1'b1; id_is_load = 1'b1; id_dst = 5'd3;
        id_uses_rs = 1'b1; id_rs = 5'd3;
        for (int n = 0; n < 2 * CMAX + 40; n++) step("sat");
        check("sat.scnt", 32'(stall_count), 32'(CMAX));

        // Reset in the middle of a flush after saturation.
        set_idle();
        branch_taken = 1'b1;
        step("satbr");
        branch_taken = 1'b0;
        rst = 1'b0;
        peek("rstfl", 1'b0, 1'b0, 1'b1, 1'b1);
        step("rstfl");
        rst = 1'b1;
        peek("rel", 1'b0, 1'b1, 1'b0, 1'b0);
        check("rel.scnt", 32'(stall_count), 32'd0);
        check("rel.fcnt", 32'(flush_count), 32'd0);
        step("rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the five-stage core. Tracks destination registers of in-flight instructions in a small shadow pipeline (EX, MEM, WB slots), detects load-use hazards against the instruction in ID, and sequences flushes on jumps and taken branches. Drives `stall_pipeline` into the ID stage, PC/IF-ID write enables, and per-stage flush strobes. Maintains saturating stall and flush event counters.

## Interface
- `REG_ADDR_W`, default 5, register address width.
- `FLUSH_CYCLES`, default 2, cycles of flush after a taken branch, counting the `branch_taken` cycle; legal range 1–7.
- `CNT_W`, default 16, event counter width.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction, not a bubble.
- `id_rs`, `id_rt`  in  `REG_ADDR_W`  source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1  each source is actually read.
- `id_reg_write`  in  1  ID instruction writes a register.
- `id_is_load`  in  1  ID instruction is a load.
- `id_dst`  in  `REG_ADDR_W`  resolved destination of the ID instruction, after the reg_dst mux.
- `id_is_jump`  in  1  unconditional jump resolved in ID.
- `branch_taken`  in  1  taken branch resolved in MEM.
- `stall_pipeline`  out  1  inserts a bubble into EX; ID holds.
- `pc_write_enable`  out  1  PC and IF/ID may update.
- `if_flush`  out  1  kill the IF/ID contents.
- `ex_flush`  out  1  kill the ID/EX and EX/MEM contents.
- `stall_count`, `flush_count`  out  `CNT_W`  saturating event counters.

## Operation
- Shadow records exist for EX, MEM and WB. Each record holds {valid, reg_write, is_load, dst}.
- Each unstalled cycle:
  - WB takes the MEM record, and MEM takes the EX record.
  - EX takes {`id_valid`, `id_reg_write`, `id_is_load`, `id_dst`}.
  - When `stall_pipeline` = 1, EX instead takes a cleared record.
- Load-use hazard exists when all of the following hold:
  - `id_valid` = 1.
  - EX record has valid = 1 and is_load = 1.
  - EX dst ≠ 0.
  - EX dst equals `id_rs` (with `id_uses_rs` = 1) or `id_rt` (with `id_uses_rt` = 1).
- ALU-to-ALU dependencies never stall, because MEM/WB forwarding exists. Register 0 never creates a hazard.
- FSM states:
  - RUN → FLUSH on `branch_taken` when `FLUSH_CYCLES` > 1; the counter loads `FLUSH_CYCLES`-1.
  - FLUSH decrements the counter each cycle and returns to RUN when it reaches 0.
  - `branch_taken` while in FLUSH reloads the counter.
- Flush priority: branch (current cycle or FLUSH state) > load-use stall > jump.
  - Branch flush: `if_flush` = 1 and `ex_flush` = 1. `stall_pipeline` = 0. On the `branch_taken` cycle, the EX and MEM records are cleared.
  - Load-use stall: `stall_pipeline` = 1 and `pc_write_enable` = 0.
  - Jump with no higher-priority event: `if_flush` = 1 for that cycle only.
- `pc_write_enable` = 1 except during a load-use stall or reset. During a branch flush it is 1 so the PC can load the target.
- Counters:
  - `stall_count` increments on each stall cycle.
  - `flush_count` increments once per `branch_taken` or applied jump event, not once per flush cycle.
  - Both saturate at all-ones.

## Timing
- `stall_pipeline`, `if_flush`, `ex_flush` and `pc_write_enable` are combinational from the registered state and the current ID/MEM inputs, so they are valid within the same cycle.
- A load-use stall lasts exactly 1 cycle. The next cycle sees a bubble in EX and the load in MEM, so there is no hazard.
- A branch flush spans cycles T .. T+`FLUSH_CYCLES`-1 after `branch_taken` at cycle T.
- While `rst` = 0 at an edge:
  - All records clear, state becomes RUN, counter becomes 0, and both event counters become 0.
  - Outputs are forced: `stall_pipeline` = 0, `pc_write_enable` = 0, `if_flush` = 1, `ex_flush` = 1.
- Reset asserted mid-flush or mid-stall aborts it. The first cycle after release is RUN with empty records.
- Simultaneous `branch_taken` and load-use: only the flush applies. `stall_count` is unchanged.

## Structure
- Shared package constants: FSM state encoding (RUN, FLUSH), the shadow-record field layout, and the zero-register index.
- One sub-module is natural: `hazard_record_pipe`, holding the three shadow records with shift, bubble and clear controls. The FSM, priority logic and counters live in the top module.

## Test plan
- Load r3 in EX while ID reads r3 as rs → `stall_pipeline` = 1 and `pc_write_enable` = 0 for exactly 1 cycle. EX then holds a bubble and `stall_count` = 1.
- Load to r0 in EX while ID reads r0 → no stall. ALU write to r5 in EX while ID reads r5 → no stall.
- `branch_taken` pulse with `FLUSH_CYCLES` = 3 → `if_flush` and `ex_flush` high for cycles T, T+1, T+2, then low. EX and MEM records are cleared and `flush_count` = 1.
- `branch_taken` with a load-use hazard in the same cycle → `stall_pipeline` = 0, flush asserted, `stall_count` unchanged.
- `id_is_jump` in RUN with no hazard → `if_flush` = 1 for 1 cycle and `ex_flush` = 0.
- `rst` = 0 during FLUSH state and after 0xFFFF stall cycles → counters read 0, state is RUN, and outputs take their forced reset values. Also check separately that `stall_count` holds at 0xFFFF (saturates) before reset.
